// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the register-file write-back controller.
package regfile_wb_ctrl_pkg;

  // Width of an index into n items. Never returns 0, so a 1-item space still gets a real bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Each bit of the write address and write data resets to this value.
  localparam logic ADDR_RST_BIT = 1'b0;
  localparam logic DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/regfile_wb_ctrl_arbiter.sv
// Combinational round-robin arbiter. Requester ptr_i has the highest priority.
module rr_arbiter
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int N = 3,
  localparam int PW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o
);

  logic found;

  // Walk the priority ring from ptr_i. The first valid requester found wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req_i[k] && ((int'(ptr_i) + off) % N == k)) begin
          found       = 1'b1;
          grant_o[k]  = 1'b1;
          grant_idx_o = PW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Round-robin write-back arbitration onto the single rd port.
// Also holds a per-register busy scoreboard for the issue stage.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int NUM_REQ             = 3,
  localparam int AW = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*AW-1:0]         req_address_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          rd_we_o,
  output logic [AW-1:0]                 rd_address_o,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  input  logic                          issue_valid_i,
  input  logic [AW-1:0]                 issue_rd_i,
  input  logic [AW-1:0]                 rs1_address_i,
  input  logic [AW-1:0]                 rs2_address_i,
  output logic                          rs1_busy_o,
  output logic                          rs2_busy_o,
  output logic [NUMBER_OF_REGISTERS-1:0] busy_o
);

  localparam int PW = idx_width(NUM_REQ);

  logic [PW-1:0]                  ptr_q, ptr_d;
  logic                           we_q, we_d;
  logic [AW-1:0]                  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]          data_q, data_d;
  logic [NUMBER_OF_REGISTERS-1:0] busy_q, busy_d;

  logic [NUM_REQ-1:0]    grant;
  logic [PW-1:0]         grant_idx;
  logic                  accept;
  logic [AW-1:0]         acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Handshake: requester k transfers on a cycle where req_valid_i[k] && req_ready_o[k].
  // The requester holds valid, address and data stable until that cycle.
  // Ready is held low while reset is asserted.
  assign req_ready_o = rst ? grant : '0;
  assign accept      = |req_ready_o;

  always_comb begin
    acc_addr = '0;
    acc_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        acc_addr = req_address_i[k*AW +: AW];
        acc_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    busy_d = busy_q;
    if (accept) begin
      ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
    // A transfer to x0 completes the handshake but never reaches the register file.
    if (accept && acc_addr != '0) begin
      we_d   = 1'b1;
      addr_d = acc_addr;
      data_d = acc_data;
    end
    // Clear is applied first, so a reserve to the same register on the same edge wins.
    if (we_q) begin
      busy_d[addr_q] = 1'b0;
    end
    if (issue_valid_i && issue_rd_i != '0) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= {AW{ADDR_RST_BIT}};
      data_q <= {DATA_WIDTH{DATA_RST_BIT}};
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign rd_we_o      = we_q;
  assign rd_address_o = addr_q;
  assign rd_data_o    = data_q;
  assign busy_o       = busy_q;
  assign rs1_busy_o   = busy_q[rs1_address_i];
  assign rs2_busy_o   = busy_q[rs2_address_i];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed vector bench for regfile_wb_ctrl (default parameters: 32 x 32, 3 requesters).
module tb_regfile_wb_ctrl;

  localparam int NR = 32;
  localparam int DW = 32;
  localparam int NQ = 3;
  localparam int AW = 5;

  logic              clk;
  logic              rst;
  logic [NQ-1:0]     req_valid;
  logic [NQ*AW-1:0]  req_address;
  logic [NQ*DW-1:0]  req_data;
  logic [NQ-1:0]     req_ready;
  logic              rd_we;
  logic [AW-1:0]     rd_address;
  logic [DW-1:0]     rd_data;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic [AW-1:0]     rs1_address;
  logic [AW-1:0]     rs2_address;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [NR-1:0]     busy;

  int n_applied = 0;
  int n_miss    = 0;

  regfile_wb_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_address_i (req_address),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .rd_we_o       (rd_we),
    .rd_address_o  (rd_address),
    .rd_data_o     (rd_data),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .rs1_address_i (rs1_address),
    .rs2_address_i (rs2_address),
    .rs1_busy_o    (rs1_busy),
    .rs2_busy_o    (rs2_busy),
    .busy_o        (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        iv;
    logic [4:0]  ird, rs1, rs2;
    logic [2:0]  e_ready;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_rs1b, e_rs2b;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(
    input logic [2:0] valid, input logic [4:0] a0, a1, a2,
    input logic [31:0] d0, d1, d2, input logic iv, input logic [4:0] ird, rs1, rs2,
    input logic [2:0] e_ready, input logic e_we, input logic [4:0] e_waddr,
    input logic [31:0] e_wdata, input logic e_rs1b, e_rs2b, input logic [31:0] e_busy);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
    v.e_ready = e_ready; v.e_we = e_we; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_rs1b = e_rs1b; v.e_rs2b = e_rs2b; v.e_busy = e_busy;
    return v;
  endfunction

  // Driver tasks
  task automatic drive(input logic [2:0] valid, input logic [4:0] a0, a1, a2,
                       input logic [31:0] d0, d1, d2, input logic iv,
                       input logic [4:0] ird, rs1, rs2);
    req_valid   = valid;
    req_address = {a2, a1, a0};
    req_data    = {d2, d1, d0};
    issue_valid = iv;
    issue_rd    = ird;
    rs1_address = rs1;
    rs2_address = rs2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vecs[0]  = mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0, 3'b001, 0, 0, 0,      0, 0, 0);
    vecs[1]  = mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0, 3'b010, 1, 1, 32'hA1, 0, 0, 0);
    vecs[2]  = mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0, 3'b100, 1, 2, 32'hA2, 0, 0, 0);
    vecs[3]  = mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0, 3'b001, 1, 3, 32'hA3, 0, 0, 0);
    vecs[4]  = mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0, 3'b010, 1, 1, 32'hA1, 0, 0, 0);
    vecs[5]  = mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0, 3'b100, 1, 2, 32'hA2, 0, 0, 0);
    vecs[6]  = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 3'b000, 1, 3, 32'hA3, 0, 0, 0);
    vecs[7]  = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 3'b000, 0, 3, 32'hA3, 0, 0, 0);
    vecs[8]  = mk(3'b001, 4, 0, 0, 32'h44, 0, 0,           0, 0, 0, 0, 3'b001, 0, 3, 32'hA3, 0, 0, 0);
    vecs[9]  = mk(3'b010, 0, 0, 0, 0, 32'h12345678, 0,     1, 0, 0, 0, 3'b010, 1, 4, 32'h44, 0, 0, 0);
    vecs[10] = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 3'b000, 0, 4, 32'h44, 0, 0, 0);
    vecs[11] = mk(3'b011, 6, 8, 0, 32'h66, 32'h88, 0,      0, 0, 0, 0, 3'b001, 0, 4, 32'h44, 0, 0, 0);
    vecs[12] = mk(3'b010, 6, 8, 0, 32'h66, 32'h88, 0,      0, 0, 0, 0, 3'b010, 1, 6, 32'h66, 0, 0, 0);
    vecs[13] = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 3'b000, 1, 8, 32'h88, 0, 0, 0);
    vecs[14] = mk(3'b000, 0, 0, 0, 0, 0, 0,                1, 7, 7, 0, 3'b000, 0, 8, 32'h88, 0, 0, 0);
    vecs[15] = mk(3'b001, 7, 0, 0, 32'h77, 0, 0,           0, 0, 7, 7, 3'b001, 0, 8, 32'h88, 1, 1, 32'h80);
    vecs[16] = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 0, 7, 0, 3'b000, 1, 7, 32'h77, 1, 0, 32'h80);
    vecs[17] = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 0, 7, 0, 3'b000, 0, 7, 32'h77, 0, 0, 0);
    vecs[18] = mk(3'b010, 0, 9, 0, 0, 32'h99, 0,           1, 9, 0, 0, 3'b010, 0, 7, 32'h77, 0, 0, 0);
    vecs[19] = mk(3'b000, 0, 0, 0, 0, 0, 0,                1, 9, 0, 9, 3'b000, 1, 9, 32'h99, 0, 1, 32'h200);
    vecs[20] = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 0, 0, 9, 3'b000, 0, 9, 32'h99, 0, 1, 32'h200);

    rst = 1'b0;
    drive(3'b111, 1, 2, 3, 1, 2, 3, 1, 4, 4, 4);
    #2;
    chk("ready_in_reset", 32'(req_ready), 0);
    next_cycle();
    next_cycle();
    chk("reset_we", 32'(rd_we), 0);
    chk("reset_waddr", 32'(rd_address), 0);
    chk("reset_wdata", rd_data, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].d0, vecs[i].d1,
            vecs[i].d2, vecs[i].iv, vecs[i].ird, vecs[i].rs1, vecs[i].rs2);
      #2;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_we", i), 32'(rd_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_waddr", i), 32'(rd_address), 32'(vecs[i].e_waddr));
      chk($sformatf("v%0d_wdata", i), rd_data, vecs[i].e_wdata);
      chk($sformatf("v%0d_rs1b", i), 32'(rs1_busy), 32'(vecs[i].e_rs1b));
      chk($sformatf("v%0d_rs2b", i), 32'(rs2_busy), 32'(vecs[i].e_rs2b));
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      next_cycle();
    end

    // Reset asserted while a write is on the rd port.
    drive(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0, 1, 3, 0, 0);
    #2;
    chk("rmid_ready0", 32'(req_ready), 32'b001);
    next_cycle();
    rst = 1'b0;
    drive(3'b010, 0, 1, 0, 0, 32'h1, 0, 0, 0, 0, 0);
    #2;
    chk("rmid_ready_rst", 32'(req_ready), 0);
    chk("rmid_we1", 32'(rd_we), 1);
    chk("rmid_waddr1", 32'(rd_address), 5);
    chk("rmid_wdata1", rd_data, 32'hDEADBEEF);
    chk("rmid_busy1", busy, 32'h208);
    next_cycle();
    rst = 1'b1;
    drive(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rmid_we2", 32'(rd_we), 0);
    chk("rmid_waddr2", 32'(rd_address), 0);
    chk("rmid_wdata2", rd_data, 0);
    chk("rmid_busy2", busy, 0);
    next_cycle();

    // Requester 2 waits one cycle behind requester 0 and keeps its data stable.
    drive(3'b101, 10, 0, 11, 32'hA0, 0, 32'hB2, 0, 0, 0, 0);
    #2;
    chk("hold_ready0", 32'(req_ready), 32'b001);
    next_cycle();
    drive(3'b100, 0, 0, 11, 0, 0, 32'hB2, 0, 0, 0, 0);
    #2;
    chk("hold_ready1", 32'(req_ready), 32'b100);
    chk("hold_we1", 32'(rd_we), 1);
    chk("hold_waddr1", 32'(rd_address), 10);
    chk("hold_wdata1", rd_data, 32'hA0);
    next_cycle();
    drive(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("hold_ready2", 32'(req_ready), 0);
    chk("hold_we2", 32'(rd_we), 1);
    chk("hold_waddr2", 32'(rd_address), 11);
    chk("hold_wdata2", rd_data, 32'hB2);
    next_cycle();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
